// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// The request fields stay stable from request until the one-cycle ack.
interface mem_wb_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage of the RV32 core: data-memory handshake, load extension, store
// lane steering and the MEM/WB pipeline register feeding write-back.
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [CTRL_W-1:0] ctrl_wb_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   pc4_mem,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   rd_mem,
    mem_wb_stage_if.master    dmem,
    output logic              stall_out,
    output logic              misalign_err,
    output logic [CTRL_W-1:0] ctrl_wb,
    output logic [XLEN-1:0]   pc4_wb,
    output logic [XLEN-1:0]   mem_data,
    output logic [XLEN-1:0]   alu_data,
    output logic [XLEN-1:0]   rd_wb
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [CTRL_W-1:0] lctrl_q, lctrl_d;
    logic [XLEN-1:0]   lpc4_q, lpc4_d;
    logic [XLEN-1:0]   lalu_q, lalu_d;
    logic [XLEN-1:0]   lrd_q, lrd_d;
    logic [CTRL_W-1:0] ctrl_wb_q, ctrl_wb_d;
    logic [XLEN-1:0]   pc4_wb_q, pc4_wb_d;
    logic [XLEN-1:0]   mem_data_q, mem_data_d;
    logic [XLEN-1:0]   alu_data_q, alu_data_d;
    logic [XLEN-1:0]   rd_wb_q, rd_wb_d;
    logic              misalign_q, misalign_d;

    logic              accept, memop, is_store, misaligned;
    logic [1:0]        off;
    logic [3:0]        be_new;
    logic [XLEN-1:0]   wdata_new;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_ext;

    // A simultaneous read and write is treated as a load.
    assign accept     = valid_in & ~flush;
    assign memop      = accept & (mem_read | mem_write);
    assign is_store   = mem_write & ~mem_read;
    assign off        = alu_result[1:0];
    assign misaligned = (funct3[1:0] == 2'b01 && off[0]) ||
                        (funct3[1] && off != 2'b00);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        be_new    = 4'b1111;
        wdata_new = rs2_data;
        if (funct3[1:0] == 2'b00) begin
            be_new    = 4'b0001 << off;
            wdata_new = {4{rs2_data[7:0]}};
        end else if (funct3[1:0] == 2'b01) begin
            be_new    = 4'b0011 << {off[1], 1'b0};
            wdata_new = {2{rs2_data[15:0]}};
        end
        if (!is_store) wdata_new = '0;
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata[8*lalu_q[1:0] +: 8];
        ld_half = lalu_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        lctrl_d    = lctrl_q;
        lpc4_d     = lpc4_q;
        lalu_d     = lalu_q;
        lrd_d      = lrd_q;
        ctrl_wb_d  = ctrl_wb_q;
        pc4_wb_d   = pc4_wb_q;
        mem_data_d = mem_data_q;
        alu_data_d = alu_data_q;
        rd_wb_d    = rd_wb_q;
        misalign_d = 1'b0;
        stall_out  = 1'b0;

        case (state_q)
            IDLE: begin
                ctrl_wb_d  = '0;
                pc4_wb_d   = '0;
                mem_data_d = '0;
                alu_data_d = '0;
                rd_wb_d    = '0;
                if (memop) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                        state_d   = BUSY;
                        req_d     = 1'b1;
                        we_d      = is_store;
                        wdata_d   = wdata_new;
                        be_d      = be_new;
                        f3_d      = funct3;
                        lctrl_d   = ctrl_wb_in;
                        lpc4_d    = pc4_mem;
                        lalu_d    = alu_result;
                        lrd_d     = rd_mem;
                    end
                end else if (accept) begin
                    ctrl_wb_d  = ctrl_wb_in;
                    pc4_wb_d   = pc4_mem;
                    alu_data_d = alu_result;
                    rd_wb_d    = rd_mem;
                end
            end
            BUSY: begin
                // Flush is deliberately not looked at here: the bus transaction must finish.
                stall_out = ~dmem.dmem_ack;
                if (dmem.dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    ctrl_wb_d  = lctrl_q;
                    pc4_wb_d   = lpc4_q;
                    alu_data_d = lalu_q;
                    rd_wb_d    = lrd_q;
                    mem_data_d = we_q ? '0 : ld_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            lctrl_q    <= '0;
            lpc4_q     <= '0;
            lalu_q     <= '0;
            lrd_q      <= '0;
            ctrl_wb_q  <= '0;
            pc4_wb_q   <= '0;
            mem_data_q <= '0;
            alu_data_q <= '0;
            rd_wb_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            lctrl_q    <= lctrl_d;
            lpc4_q     <= lpc4_d;
            lalu_q     <= lalu_d;
            lrd_q      <= lrd_d;
            ctrl_wb_q  <= ctrl_wb_d;
            pc4_wb_q   <= pc4_wb_d;
            mem_data_q <= mem_data_d;
            alu_data_q <= alu_data_d;
            rd_wb_q    <= rd_wb_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {lalu_q[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign misalign_err    = misalign_q;
    assign ctrl_wb         = ctrl_wb_q;
    assign pc4_wb          = pc4_wb_q;
    assign mem_data        = mem_data_q;
    assign alu_data        = alu_data_q;
    assign rd_wb           = rd_wb_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus the MEM/WB pipeline register of the 32-bit RISC-V core.
- Takes the address and store data computed in EX.
- Drives a handshaked data-memory bus and performs load sign/zero extension and store byte-lane steering.
- Registers ctrl_wb, pc4_wb, mem_data, alu_data and rd_wb, which feed the write-back stage directly; stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath/address width.
- CTRL_W, 3, width of the write-back control bundle (bit0 reg write, bit1 select mem_data, bit2 select pc4).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  EX/MEM holds a valid instruction
- flush  in  1  discard the instruction presented this cycle
- ctrl_wb_in  in  CTRL_W  write-back control from EX
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- pc4_mem  in  XLEN  PC+4 of the instruction
- alu_result  in  XLEN  ALU result / effective address
- rs2_data  in  XLEN  store data
- rd_mem  in  XLEN  destination register index (zero-extended)
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  out  XLEN  lane-steered store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  XLEN  read word, valid with ack
- dmem_ack  in  1  one-cycle completion strobe
- stall_out  out  1  upstream must hold its outputs
- misalign_err  out  1  one-cycle pulse on misaligned access
- ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb  out  CTRL_W/XLEN×4  MEM/WB register to write-back

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata=0; all WB outputs=0 (bubble); misalign_err=0. A reset during BUSY abandons the transaction; a late ack after reset is ignored.
- memop = valid_in & (mem_read | mem_write).
- Alignment rule: H/HU need addr[0]=0; W needs addr[1:0]=00. B is always aligned.
- FSM IDLE:
  - flush=1 or valid_in=0: at the edge, WB regs load a bubble (ctrl_wb=000, others 0).
  - Valid non-memory op: at the edge, WB regs load ctrl_wb_in, pc4_mem, alu_result, rd_mem, with mem_data=0. Latency 1 cycle, no stall.
  - Aligned memop: stall_out=1 combinationally. At the edge, latch the request (addr, we, be, wdata, funct3, addr[1:0], WB fields), set dmem_req=1, load a WB bubble, and go to BUSY.
  - Misaligned memop: no request. At the edge, misalign_err=1 for one cycle and a WB bubble loads.
- FSM BUSY:
  - dmem_req stays 1; request fields stay stable; stall_out=~dmem_ack; WB regs hold the bubble.
  - On the edge with dmem_ack=1: WB regs load the latched fields, with mem_data=extended load data (0 for stores). dmem_req drops to 0 and the FSM returns to IDLE.
  - flush is ignored in BUSY.
- Minimum load/store latency: 2 cycles from presentation to WB output.
- Loads: select the byte/half by the latched addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Stores: SB gives be=0001<<addr[1:0] and wdata={4{rs2[7:0]}}. SH gives be=0011<<addr[1] (×2 lanes) and wdata={2{rs2[15:0]}}. SW gives be=1111 and wdata=rs2.
- If mem_read and mem_write are both 1, the op is treated as a load.
- ctrl_wb passes through unchanged. For non-memops, stall_out is never asserted.

Test Plan:
- Reset mid-BUSY (LW issued, rst_n low before ack) -> dmem_req=0, ctrl_wb=000 immediately; a following ack produces no WB update.
- ALU op: ctrl_wb_in=001, alu_result=3, pc4_mem=1, rd_mem=4 -> one cycle later ctrl_wb=001, alu_data=3, pc4_wb=1, rd_wb=4, stall_out=0.
- LB at addr 0x102, rdata=0x00800000, ack 3 cycles after req -> dmem_addr=0x100, mem_data=0xFFFFFF80, ctrl_wb=011; stall_out high until the ack cycle. LBU on the same data -> mem_data=0x00000080.
- SH at addr 0x206, rs2=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, mem_data=0.
- LW at addr 0x101 -> no dmem_req; misalign_err pulses once; ctrl_wb=000; next op accepted normally.
- flush with a valid ALU op -> ctrl_wb=000 next cycle; flush raised in BUSY -> transaction still completes with correct mem_data.
